// File: rtl/cpu_pkg.sv
// Register-file constants and helpers shared across the CPU datapath.
package cpu_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned DATA_W  = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Write, read and debug signals of the 2-read/1-write register file.
interface reg_file_2r1w_if
  import cpu_pkg::*;
#(
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned CNT_W = 16
);

  logic             we;
  reg_addr_t        wa;
  logic [DW-1:0]    wd;
  reg_addr_t        ra1;
  reg_addr_t        ra2;
  logic [DW-1:0]    rd1;
  logic [DW-1:0]    rd2;
  reg_addr_t        dbg_ra;
  logic [DW-1:0]    dbg_data;
  logic [CNT_W-1:0] wr_cnt;
  reg_addr_t        last_wa;

  modport master (
    output we, wa, wd, ra1, ra2, dbg_ra,
    input  rd1, rd2, dbg_data, wr_cnt, last_wa
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, dbg_ra,
    output rd1, rd2, dbg_data, wr_cnt, last_wa
  );

endinterface

// File: rtl/reg_rd_port.sv
// One combinational read port: storage select, r0 zero force and optional write bypass.
module reg_rd_port
  import cpu_pkg::*;
#(
  parameter int unsigned DW     = DATA_W,
  parameter bit          BYPASS = 1'b0
) (
  input  logic [DW-1:0] regs [REG_NUM],
  input  reg_addr_t     ra,
  input  logic          we,
  input  reg_addr_t     wa,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd
);

  always_comb begin
    rd = regs[ra];
    if (BYPASS && we && (wa == ra)) begin
      rd = wd;
    end
    // r0 wins over bypass: it is never stored and never forwarded
    if (is_zero_reg(ra)) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32 x DW register file: two async read ports, one sync write port, debug read port
// and a counter of committed writes.
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int unsigned DW     = DATA_W,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input logic            clk,
  input logic            rst_n,
  reg_file_2r1w_if.slave bus
);

  logic [DW-1:0]    regs_q [REG_NUM];
  logic [CNT_W-1:0] wr_cnt_q;
  reg_addr_t        last_wa_q;
  logic             wr_en;
  logic             byp_we;

  assign wr_en  = bus.we && !is_zero_reg(bus.wa);
  // Keeps bypassed data off the read ports while reset holds storage at zero
  assign byp_we = bus.we && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q  <= '0;
      last_wa_q <= REG_ZERO;
    end else if (wr_en) begin
      regs_q[bus.wa] <= bus.wd;
      wr_cnt_q       <= wr_cnt_q + CNT_W'(1);
      last_wa_q      <= bus.wa;
    end
  end

  assign bus.wr_cnt  = wr_cnt_q;
  assign bus.last_wa = last_wa_q;

  reg_rd_port #(.DW(DW), .BYPASS(BYPASS)) u_rd1 (
    .regs (regs_q),
    .ra   (bus.ra1),
    .we   (byp_we),
    .wa   (bus.wa),
    .wd   (bus.wd),
    .rd   (bus.rd1)
  );

  reg_rd_port #(.DW(DW), .BYPASS(BYPASS)) u_rd2 (
    .regs (regs_q),
    .ra   (bus.ra2),
    .we   (byp_we),
    .wa   (bus.wa),
    .wd   (bus.wd),
    .rd   (bus.rd2)
  );

  reg_rd_port #(.DW(DW), .BYPASS(BYPASS)) u_dbg (
    .regs (regs_q),
    .ra   (bus.dbg_ra),
    .we   (byp_we),
    .wa   (bus.wa),
    .wd   (bus.wd),
    .rd   (bus.dbg_data)
  );

  wa_known_a : assert property (@(posedge clk) disable iff (!rst_n)
    bus.we |-> !$isunknown(bus.wa));

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench: one non-bypass and one bypass register file driven side by side.
module tb_reg_file_2r1w;

  logic clk;
  logic rst_n;

  reg_file_2r1w_if #(.DW(32), .CNT_W(16)) bus0 ();
  reg_file_2r1w_if #(.DW(32), .CNT_W(16)) bus1 ();

  assign bus1.we     = bus0.we;
  assign bus1.wa     = bus0.wa;
  assign bus1.wd     = bus0.wd;
  assign bus1.ra1    = bus0.ra1;
  assign bus1.ra2    = bus0.ra2;
  assign bus1.dbg_ra = bus0.dbg_ra;

  reg_file_2r1w #(.DW(32), .BYPASS(1'b0), .CNT_W(16)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  reg_file_2r1w #(.DW(32), .BYPASS(1'b1), .CNT_W(16)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_ra;
    logic [31:0] pre_rd1_b0;
    logic [31:0] pre_rd1_b1;
    logic [31:0] pre_dbg_b0;
    logic [31:0] pre_dbg_b1;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg;
    logic [15:0] cnt;
    logic [4:0]  last;
  } vec_t;

  vec_t vecs [6];
  int   n_vec;
  int   n_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_both(input string name, input logic [31:0] exp);
    case (name)
      "rd1":  begin check("b0 rd1", bus0.rd1, exp);  check("b1 rd1", bus1.rd1, exp); end
      "rd2":  begin check("b0 rd2", bus0.rd2, exp);  check("b1 rd2", bus1.rd2, exp); end
      "dbg":  begin
        check("b0 dbg", bus0.dbg_data, exp);
        check("b1 dbg", bus1.dbg_data, exp);
      end
      "cnt":  begin
        check("b0 wr_cnt", 32'(bus0.wr_cnt), exp);
        check("b1 wr_cnt", 32'(bus1.wr_cnt), exp);
      end
      default: begin
        check("b0 last_wa", 32'(bus0.last_wa), exp);
        check("b1 last_wa", 32'(bus1.last_wa), exp);
      end
    endcase
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] dbg_ra);
    bus0.we     = we;
    bus0.wa     = wa;
    bus0.wd     = wd;
    bus0.ra1    = ra1;
    bus0.ra2    = ra2;
    bus0.dbg_ra = dbg_ra;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    //           we    wa     wd             ra1    ra2    dbg    pre_rd1_b0     pre_rd1_b1
    //           pre_dbg_b0     pre_dbg_b1     rd1            rd2            dbg            cnt    last
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF,
                32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 16'd1, 5'd5};
    vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  5'd0,  32'h00000000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 16'd1, 5'd5};
    vecs[2] = '{1'b1, 5'd31, 32'h00400004, 5'd31, 5'd31, 5'd31, 32'h00000000, 32'h00400004,
                32'h00000000, 32'h00400004, 32'h00400004, 32'h00400004, 32'h00400004, 16'd2, 5'd31};
    vecs[3] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd31, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00400004, 32'hDEADBEEF, 16'd2, 5'd31};
    vecs[4] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd5,  5'd31, 32'hDEADBEEF, 32'h11111111,
                32'h00400004, 32'h00400004, 32'h11111111, 32'h11111111, 32'h00400004, 16'd3, 5'd5};
    vecs[5] = '{1'b1, 5'd1,  32'hCAFEF00D, 5'd2,  5'd1,  5'd1,  32'h00000000, 32'h00000000,
                32'h00000000, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 16'd4, 5'd1};

    // Reset: outputs are zero while asserted and after release
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd5);
    #2;
    check_both("rd1", 32'h0);
    check_both("cnt", 32'h0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
      #1;
      check_both("rd1", 32'h0);
      check_both("rd2", 32'h0);
      check_both("dbg", 32'h0);
    end
    check_both("cnt", 32'h0);
    check_both("last", 32'h0);

    // Table vectors: before-edge view (bypass differs), then after-edge state
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2, vecs[i].dbg_ra);
      #2;
      check($sformatf("v%0d b0 pre rd1", i), bus0.rd1, vecs[i].pre_rd1_b0);
      check($sformatf("v%0d b1 pre rd1", i), bus1.rd1, vecs[i].pre_rd1_b1);
      check($sformatf("v%0d b0 pre dbg", i), bus0.dbg_data, vecs[i].pre_dbg_b0);
      check($sformatf("v%0d b1 pre dbg", i), bus1.dbg_data, vecs[i].pre_dbg_b1);
      @(posedge clk);
      #1;
      check_both("rd1", vecs[i].rd1);
      check_both("rd2", vecs[i].rd2);
      check_both("dbg", vecs[i].dbg);
      check_both("cnt", 32'(vecs[i].cnt));
      check_both("last", 32'(vecs[i].last));
    end

    // Counter wrap: bring wr_cnt from 4 up to 0xFFFF, then one more write
    for (int i = 0; i < 65535 - 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd2, 32'(i), 5'd2, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 5'd31);
    #1;
    check_both("cnt", 32'h0000FFFF);
    check_both("rd1", 32'd65530);
    check_both("rd2", 32'hCAFEF00D);
    check_both("dbg", 32'h00400004);
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h99990009, 5'd9, 5'd2, 5'd9);
    @(posedge clk);
    #1;
    check_both("cnt", 32'h0);
    check_both("last", 32'd9);
    check_both("rd1", 32'h99990009);
    check_both("rd2", 32'd65530);

    // Mid-cycle reset clears storage at once; a write under reset is lost
    @(negedge clk);
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd9, 5'd7);
    @(posedge clk);
    #1;
    check_both("rd1", 32'hA5A5A5A5);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 5'd7);
    #2 rst_n = 1'b0;
    #1;
    check_both("rd1", 32'h0);
    check_both("rd2", 32'h0);
    check_both("cnt", 32'h0);
    check_both("last", 32'h0);
    drive(1'b1, 5'd7, 32'h12341234, 5'd7, 5'd7, 5'd7);
    #1;
    check_both("rd1", 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst b0 rd1", bus0.rd1, 32'h0);
    check("rst b1 rd1 bypass", bus1.rd1, 32'h12341234);
    check_both("cnt", 32'h0);
    @(posedge clk);
    #1;
    check_both("rd1", 32'h12341234);
    check_both("cnt", 32'd1);
    check_both("last", 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
